// File: rtl/load_store_unit_if.sv
// load_store_unit_if: request, response and memory-bus signals of the
// load/store unit, grouped so the unit and its environment connect by modport.
// master = the load/store unit itself; slave = the pipeline/memory side.
interface load_store_unit_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    // Request from the execute/memory stage
    logic                    iReqValid;
    logic                    oReqReady;
    logic                    iReqWrite;
    logic [1:0]              iReqSize;
    logic                    iReqUnsigned;
    logic [ADDR_WIDTH-1:0]   iReqAddr;
    logic [DATA_WIDTH-1:0]   iReqWData;
    // Response back to the pipeline
    logic                    oRspValid;
    logic [DATA_WIDTH-1:0]   oRspRData;
    logic                    oRspErr;
    // Word-addressed memory bus
    logic                    oMemValid;
    logic                    iMemReady;
    logic                    oMemWrite;
    logic [ADDR_WIDTH-1:0]   oMemAddr;
    logic [DATA_WIDTH-1:0]   oMemWData;
    logic [DATA_WIDTH/8-1:0] oMemByteEn;
    logic                    iMemRValid;
    logic [DATA_WIDTH-1:0]   iMemRData;

    modport master (
        input  iReqValid, iReqWrite, iReqSize, iReqUnsigned, iReqAddr, iReqWData,
        output oReqReady,
        output oRspValid, oRspRData, oRspErr,
        output oMemValid, oMemWrite, oMemAddr, oMemWData, oMemByteEn,
        input  iMemReady, iMemRValid, iMemRData
    );

    modport slave (
        output iReqValid, iReqWrite, iReqSize, iReqUnsigned, iReqAddr, iReqWData,
        input  oReqReady,
        input  oRspValid, oRspRData, oRspErr,
        input  oMemValid, oMemWrite, oMemAddr, oMemWData, oMemByteEn,
        output iMemReady, iMemRValid, iMemRData
    );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: initiator side of the data-memory port. Accepts one
// load/store at a time, issues word-aligned beats with byte enables, lane-shifts
// store data and extracts/extends load data.
// Optional feature: define MISALIGNED_SPLIT_EN to split word-crossing accesses
// into two beats; without it such accesses are rejected with oRspErr=1 and no
// memory beat is issued. Only DATA_WIDTH=32 is supported.
module load_store_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic              iClk,
    input  logic              iRst_n,
    load_store_unit_if.master bus
);

`ifdef MISALIGNED_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        BEAT0    = 3'd1,
        RD_WAIT0 = 3'd2,
        BEAT1    = 3'd3,
        RD_WAIT1 = 3'd4,
        RESP     = 3'd5
    } state_t;

    state_t state_q, state_d;

    // Request fields captured at accept
    logic                    write_q;
    logic [1:0]              size_q;
    logic                    unsigned_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [7:0]              be_q;      // [3:0] beat 0 lanes, [7:4] beat 1 lanes
    logic [2*DATA_WIDTH-1:0] wdata_q;   // [31:0] beat 0 data, [63:32] beat 1 data
    logic                    split_q;
    // Read data already captured for the current beat (arrived in its handshake cycle)
    logic                    got_q;
    logic [DATA_WIDTH-1:0]   rdata0_q;
    logic [DATA_WIDTH-1:0]   rdata1_q;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q;
    logic                    rsp_err_q;

    logic                    accept;
    logic                    hs;
    logic                    rd_done;
    logic [7:0]              acc_be;
    logic                    acc_split;
    logic                    in_beat0;
    logic                    in_beat1;
    logic [DATA_WIDTH-1:0]   rd0_w;
    logic [DATA_WIDTH-1:0]   rd1_w;
    logic [DATA_WIDTH-1:0]   ld_word;

    // Byte-lane mask across two words: bits above lane 3 belong to beat 1.
    function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        logic [7:0] base;
        case (size)
            2'b00:   base = 8'h01;
            2'b01:   base = 8'h03;
            default: base = 8'h0F;
        endcase
        return base << off;
    endfunction

    // Keep the low size bytes of a right-justified word and extend them.
    function automatic logic [DATA_WIDTH-1:0] extend_load(input logic [DATA_WIDTH-1:0] w,
                                                          input logic [1:0] size,
                                                          input logic uns);
        case (size)
            2'b00:   return uns ? {{(DATA_WIDTH-8){1'b0}}, w[7:0]}
                                : {{(DATA_WIDTH-8){w[7]}}, w[7:0]};
            2'b01:   return uns ? {{(DATA_WIDTH-16){1'b0}}, w[15:0]}
                                : {{(DATA_WIDTH-16){w[15]}}, w[15:0]};
            default: return w;
        endcase
    endfunction

    assign accept    = bus.iReqValid & bus.oReqReady;
    assign acc_be    = lane_mask(bus.iReqSize, bus.iReqAddr[1:0]);
    assign acc_split = |acc_be[7:4];
    assign in_beat0  = (state_q == BEAT0);
    assign in_beat1  = (state_q == BEAT1);
    assign hs        = bus.oMemValid & bus.iMemReady;
    assign rd_done   = got_q | bus.iMemRValid;

    // Read word of the beat being completed comes straight from the bus unless it
    // was captured earlier, so the response is registered on the same edge.
    assign rd0_w   = (state_q == RD_WAIT0 && !got_q) ? bus.iMemRData : rdata0_q;
    assign rd1_w   = (state_q == RD_WAIT1 && !got_q) ? bus.iMemRData : rdata1_q;
    assign ld_word = DATA_WIDTH'({rd1_w, rd0_w} >> {addr_q[1:0], 3'b000});

    assign bus.oReqReady  = (state_q == IDLE);
    assign bus.oRspValid  = (state_q == RESP);
    assign bus.oRspRData  = rsp_rdata_q;
    assign bus.oRspErr    = rsp_err_q;
    assign bus.oMemValid  = in_beat0 | in_beat1;
    assign bus.oMemWrite  = (in_beat0 | in_beat1) & write_q;
    assign bus.oMemAddr   = in_beat0 ? {addr_q[ADDR_WIDTH-1:2], 2'b00} :
                            in_beat1 ? {addr_q[ADDR_WIDTH-1:2] + {{(ADDR_WIDTH-3){1'b0}}, 1'b1}, 2'b00} :
                                       '0;
    assign bus.oMemByteEn = in_beat0 ? be_q[3:0] : in_beat1 ? be_q[7:4] : 4'b0000;
    assign bus.oMemWData  = !write_q ? '0 :
                            in_beat0 ? wdata_q[DATA_WIDTH-1:0] :
                            in_beat1 ? wdata_q[2*DATA_WIDTH-1:DATA_WIDTH] : '0;

    // State register; reset abandons any access in flight.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic. A load whose first word arrives with the beat-0 handshake
    // goes straight on to beat 1; the final read wait always lasts at least one
    // cycle because the response word is assembled and registered there.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) state_d = (acc_split && !SPLIT_EN) ? RESP : BEAT0;
            end
            BEAT0: begin
                if (hs) begin
                    if (write_q)                        state_d = split_q ? BEAT1 : RESP;
                    else if (split_q && bus.iMemRValid) state_d = BEAT1;
                    else                                state_d = RD_WAIT0;
                end
            end
            RD_WAIT0: begin
                if (rd_done) state_d = split_q ? BEAT1 : RESP;
            end
            BEAT1: begin
                if (hs) state_d = write_q ? RESP : RD_WAIT1;
            end
            RD_WAIT1: begin
                if (rd_done) state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request capture, read-word capture and registered response.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            write_q     <= 1'b0;
            size_q      <= 2'b00;
            unsigned_q  <= 1'b0;
            addr_q      <= '0;
            be_q        <= 8'h00;
            wdata_q     <= '0;
            split_q     <= 1'b0;
            got_q       <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        write_q     <= bus.iReqWrite;
                        size_q      <= bus.iReqSize;
                        unsigned_q  <= bus.iReqUnsigned;
                        addr_q      <= bus.iReqAddr;
                        be_q        <= acc_be;
                        wdata_q     <= {bus.iReqWData, bus.iReqWData} << {bus.iReqAddr[1:0], 3'b000};
                        split_q     <= acc_split;
                        got_q       <= 1'b0;
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= acc_split & !SPLIT_EN;
                    end
                end
                BEAT0: begin
                    if (hs && !write_q && bus.iMemRValid) begin
                        rdata0_q <= bus.iMemRData;
                        got_q    <= !split_q;
                    end
                end
                RD_WAIT0: begin
                    if (rd_done) begin
                        rdata0_q <= rd0_w;
                        got_q    <= 1'b0;
                        if (!split_q) rsp_rdata_q <= extend_load(ld_word, size_q, unsigned_q);
                    end
                end
                BEAT1: begin
                    if (hs && !write_q && bus.iMemRValid) begin
                        rdata1_q <= bus.iMemRData;
                        got_q    <= 1'b1;
                    end
                end
                RD_WAIT1: begin
                    if (rd_done) begin
                        rdata1_q    <= rd1_w;
                        got_q       <= 1'b0;
                        rsp_rdata_q <= extend_load(ld_word, size_q, unsigned_q);
                    end
                end
                RESP: begin
                    rsp_rdata_q <= '0;
                    rsp_err_q   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: table-driven bench for load_store_unit with a response
// scoreboard and hand-written stall, delayed-read and mid-access reset sequences.
module tb_load_store_unit;

`ifdef MISALIGNED_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    typedef struct {
        bit        wr;
        bit [1:0]  size;
        bit        uns;
        bit [31:0] addr;
        bit [31:0] wdata;
        bit [31:0] rd0;
        bit [31:0] rd1;
        bit [3:0]  be0;
        bit [31:0] wd0;
        bit [3:0]  be1;
        bit [31:0] wd1;
        bit        split;
        bit [31:0] rdata;
    } vec_t;

    typedef struct {
        bit [31:0] rdata;
        bit        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb[$];
    vec_t vt[$];

    load_store_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .iClk   (clk),
        .iRst_n (rst_n),
        .bus    (bus.master)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic run_vec(input vec_t v, input int dly, input int stall);
        exp_t      e;
        exp_t      got_e;
        bit        err_exp;
        int        nb;
        int        t0;
        int        lat;
        bit        seen;
        bit        stray;
        bit [31:0] base;
        err_exp = v.split && !SPLIT;
        nb      = err_exp ? 0 : (v.split ? 2 : 1);
        base    = v.addr & 32'hFFFF_FFFC;
        e.rdata = err_exp ? 32'h0 : v.rdata;
        e.err   = err_exp;
        sb.push_back(e);

        @(negedge clk);
        bus.iReqValid    = 1'b1;
        bus.iReqWrite    = v.wr;
        bus.iReqSize     = v.size;
        bus.iReqUnsigned = v.uns;
        bus.iReqAddr     = v.addr;
        bus.iReqWData    = v.wdata;
        chk("req_ready", 32'(bus.oReqReady), 32'd1);
        t0 = cyc;
        @(posedge clk);
        #1 bus.iReqValid = 1'b0;

        for (int b = 0; b < nb; b++) begin
            seen = 1'b0;
            for (int g = 0; g < 20 && !seen; g++) begin
                @(negedge clk);
                seen = bus.oMemValid;
            end
            chk("beat_valid", 32'(seen), 32'd1);
            if (b == 0) begin
                for (int s = 0; s < stall; s++) begin
                    chk("stall_valid", 32'(bus.oMemValid), 32'd1);
                    chk("stall_addr", bus.oMemAddr, base);
                    chk("stall_be", 32'(bus.oMemByteEn), 32'(v.be0));
                    chk("stall_wdata", bus.oMemWData, v.wd0);
                    chk("stall_ready", 32'(bus.oReqReady), 32'd0);
                    @(negedge clk);
                end
            end
            chk("beat_addr", bus.oMemAddr, (b == 0) ? base : base + 32'd4);
            chk("beat_be", 32'(bus.oMemByteEn), 32'((b == 0) ? v.be0 : v.be1));
            chk("beat_write", 32'(bus.oMemWrite), 32'(v.wr));
            if (v.wr) chk("beat_wdata", bus.oMemWData, (b == 0) ? v.wd0 : v.wd1);
            bus.iMemReady  = 1'b1;
            bus.iMemRValid = !v.wr && (dly == 0);
            bus.iMemRData  = (b == 0) ? v.rd0 : v.rd1;
            @(posedge clk);
            #1;
            bus.iMemReady  = 1'b0;
            bus.iMemRValid = 1'b0;
            if (!v.wr && dly > 0) begin
                repeat (dly) @(negedge clk);
                @(negedge clk);
                bus.iMemRValid = 1'b1;
                bus.iMemRData  = (b == 0) ? v.rd0 : v.rd1;
                @(posedge clk);
                #1 bus.iMemRValid = 1'b0;
            end
        end

        seen  = 1'b0;
        stray = 1'b0;
        for (int g = 0; g < 20 && !seen; g++) begin
            @(negedge clk);
            if (bus.oMemValid) stray = 1'b1;
            seen = bus.oRspValid;
        end
        chk("rsp_seen", 32'(seen), 32'd1);
        chk("no_extra_beat", 32'(stray), 32'd0);
        if (seen) begin
            if (dly == 0 && stall == 0) begin
                if (err_exp)   lat = 1;
                else if (v.wr) lat = v.split ? 3 : 2;
                else           lat = v.split ? 4 : 3;
                chk("latency", 32'(cyc - t0), 32'(lat));
            end
            chk("rsp_ready_low", 32'(bus.oReqReady), 32'd0);
            if (sb.size() > 0) begin
                got_e = sb.pop_front();
                chk("rsp_rdata", bus.oRspRData, got_e.rdata);
                chk("rsp_err", 32'(bus.oRspErr), 32'(got_e.err));
            end else begin
                chk("sb_underflow", 32'd1, 32'(sb.size()));
            end
            @(negedge clk);
            chk("rsp_pulse", 32'(bus.oRspValid), 32'd0);
        end
    endtask

    initial begin
        bit stray;
        bus.iReqValid    = 1'b0;
        bus.iReqWrite    = 1'b0;
        bus.iReqSize     = 2'b00;
        bus.iReqUnsigned = 1'b0;
        bus.iReqAddr     = 32'h0;
        bus.iReqWData    = 32'h0;
        bus.iMemReady    = 1'b0;
        bus.iMemRValid   = 1'b0;
        bus.iMemRData    = 32'h0;

        //         wr sz   uns addr          wdata         rd0           rd1           be0   wd0           be1   wd1           spl rdata
        vt.push_back('{1'b1, 2'd2, 1'b0, 32'h0001_0000, 32'hDEAD_BEEF, 32'h0,        32'h0,        4'hF, 32'hDEAD_BEEF, 4'h0, 32'h0,        1'b0, 32'h0});
        vt.push_back('{1'b0, 2'd2, 1'b0, 32'h0001_0000, 32'h0,        32'hDEAD_BEEF, 32'h0,        4'hF, 32'h0,        4'h0, 32'h0,        1'b0, 32'hDEAD_BEEF});
        vt.push_back('{1'b0, 2'd0, 1'b0, 32'h0001_0003, 32'h0,        32'h8000_0000, 32'h0,        4'h8, 32'h0,        4'h0, 32'h0,        1'b0, 32'hFFFF_FF80});
        vt.push_back('{1'b0, 2'd0, 1'b1, 32'h0001_0003, 32'h0,        32'h8000_0000, 32'h0,        4'h8, 32'h0,        4'h0, 32'h0,        1'b0, 32'h0000_0080});
        vt.push_back('{1'b1, 2'd1, 1'b0, 32'h0001_0002, 32'h0000_1234, 32'h0,        32'h0,        4'hC, 32'h1234_0000, 4'h0, 32'h0,        1'b0, 32'h0});
        vt.push_back('{1'b0, 2'd1, 1'b0, 32'h0001_0001, 32'h0,        32'h00AB_CD00, 32'h0,        4'h6, 32'h0,        4'h0, 32'h0,        1'b0, 32'hFFFF_ABCD});
        vt.push_back('{1'b0, 2'd2, 1'b0, 32'h0001_0001, 32'h0,        32'h4433_2211, 32'h8877_6655, 4'hE, 32'h0,        4'h1, 32'h0,        1'b1, 32'h5544_3322});
        vt.push_back('{1'b1, 2'd2, 1'b0, 32'h0001_0003, 32'hAABB_CCDD, 32'h0,        32'h0,        4'h8, 32'hDD00_0000, 4'h7, 32'hDDAA_BBCC, 1'b1, 32'h0});
        vt.push_back('{1'b0, 2'd1, 1'b1, 32'h0001_0003, 32'h0,        32'hAB00_0000, 32'h0000_00CD, 4'h8, 32'h0,        4'h1, 32'h0,        1'b1, 32'h0000_CDAB});
        vt.push_back('{1'b0, 2'd1, 1'b0, 32'h0001_0003, 32'h0,        32'hAB00_0000, 32'h0000_00CD, 4'h8, 32'h0,        4'h1, 32'h0,        1'b1, 32'hFFFF_CDAB});
        vt.push_back('{1'b1, 2'd0, 1'b0, 32'h0001_0001, 32'h0000_005A, 32'h0,        32'h0,        4'h2, 32'h0000_5A00, 4'h0, 32'h0,        1'b0, 32'h0});
        vt.push_back('{1'b0, 2'd0, 1'b0, 32'h0001_0000, 32'h0,        32'h0000_007F, 32'h0,        4'h1, 32'h0,        4'h0, 32'h0,        1'b0, 32'h0000_007F});
        vt.push_back('{1'b0, 2'd3, 1'b0, 32'h0001_0008, 32'h0,        32'h1234_5678, 32'h0,        4'hF, 32'h0,        4'h0, 32'h0,        1'b0, 32'h1234_5678});
        vt.push_back('{1'b0, 2'd2, 1'b0, 32'hFFFF_FFFE, 32'h0,        32'h2211_0000, 32'h0000_4433, 4'hC, 32'h0,        4'h3, 32'h0,        1'b1, 32'h4433_2211});
        vt.push_back('{1'b1, 2'd1, 1'b0, 32'h0001_0001, 32'h0000_BEEF, 32'h0,        32'h0,        4'h6, 32'h00BE_EF00, 4'h0, 32'h0,        1'b0, 32'h0});
        vt.push_back('{1'b0, 2'd1, 1'b1, 32'h0001_0002, 32'h0,        32'h8001_0000, 32'h0,        4'hC, 32'h0,        4'h0, 32'h0,        1'b0, 32'h0000_8001});

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 32'(bus.oReqReady), 32'd1);
        chk("rst_rsp_valid", 32'(bus.oRspValid), 32'd0);
        chk("rst_rsp_rdata", bus.oRspRData, 32'h0);
        chk("rst_rsp_err", 32'(bus.oRspErr), 32'd0);
        chk("rst_mem_valid", 32'(bus.oMemValid), 32'd0);
        chk("rst_mem_write", 32'(bus.oMemWrite), 32'd0);
        chk("rst_mem_addr", bus.oMemAddr, 32'h0);
        chk("rst_mem_be", 32'(bus.oMemByteEn), 32'd0);
        chk("rst_mem_wdata", bus.oMemWData, 32'h0);
        rst_n = 1'b1;

        foreach (vt[i]) run_vec(vt[i], 0, 0);

        // Memory not ready for 5 cycles in BEAT0
        run_vec('{1'b1, 2'd2, 1'b0, 32'h0001_0004, 32'hCAFE_F00D, 32'h0, 32'h0,
                  4'hF, 32'hCAFE_F00D, 4'h0, 32'h0, 1'b0, 32'h0}, 0, 5);
        // Read data arriving late in RD_WAITn, aligned and split
        run_vec('{1'b0, 2'd1, 1'b1, 32'h0001_0000, 32'h0, 32'h0000_FFFE, 32'h0,
                  4'h3, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0000_FFFE}, 3, 0);
        run_vec('{1'b0, 2'd2, 1'b0, 32'h0001_0002, 32'h0, 32'h5678_DEAD, 32'hBEEF_1234,
                  4'hC, 32'h0, 4'h3, 32'h0, 1'b1, 32'h1234_5678}, 2, 0);

        // Asynchronous reset while waiting for read data
        @(negedge clk);
        bus.iReqValid    = 1'b1;
        bus.iReqWrite    = 1'b0;
        bus.iReqSize     = 2'd2;
        bus.iReqUnsigned = 1'b0;
        bus.iReqAddr     = 32'h0001_0000;
        @(posedge clk);
        #1 bus.iReqValid = 1'b0;
        @(negedge clk);
        chk("rw_beat_valid", 32'(bus.oMemValid), 32'd1);
        bus.iMemReady = 1'b1;
        @(posedge clk);
        #1 bus.iMemReady = 1'b0;
        @(negedge clk);
        chk("rw_ready_low", 32'(bus.oReqReady), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_mem_valid", 32'(bus.oMemValid), 32'd0);
        chk("arst_req_ready", 32'(bus.oReqReady), 32'd1);
        @(negedge clk);
        rst_n          = 1'b1;
        bus.iMemRValid = 1'b1;
        bus.iMemRData  = 32'h1234_5678;
        stray          = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (bus.oRspValid) stray = 1'b1;
        end
        bus.iMemRValid = 1'b0;
        chk("late_rvalid_no_rsp", 32'(stray), 32'd0);

        // Unit must still work after the abandoned access
        run_vec('{1'b0, 2'd0, 1'b1, 32'h0001_0002, 32'h0, 32'h00C3_0000, 32'h0,
                  4'h4, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0000_00C3}, 0, 0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
